regfile_write_ctrl: RTL

//  Write-side companion to the register-file read decoders. Buffers write-back requests
//  (dest RegId + data) in a small FIFO and drains at most one per cycle into the register

---
 rtl/regfile_write_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_ctrl
// Brief    : Write-back FIFO draining one-hot RF writes, with read-port forwarding
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_ctrl #(
  parameter int DEPTH = 2,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [3:0]    wb_regid,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          rf_hold,
  output logic          WriteEn,
  output logic [15:0]   WriteWordline,
  output logic [DW-1:0] WriteData,
  input  logic [3:0]    SrcReg1,
  input  logic [3:0]    SrcReg2,
  output logic          fwd1_hit,
  output logic [DW-1:0] fwd1_data,
  output logic          fwd2_hit,
  output logic [DW-1:0] fwd2_data
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH) + 1;
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);

  logic [3:0]      r_regid [DEPTH];
  logic [DW-1:0]   r_data  [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [c_aw-1:0] r_head;
  logic [c_aw-1:0] r_tail;
  logic [c_cw-1:0] r_count;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [3:0]      w_src   [2];
  logic [1:0]      w_hit;
  logic [DW-1:0]   w_fdata [2];
  logic [c_aw-1:0] w_idx;

  // Ready depends only on reset and occupancy so it never waits on RF back-pressure.
  assign wb_ready = !rst && (r_count < c_depth);
  assign w_accept = wb_valid && wb_ready;
  // Register 0 is hardwired zero: the handshake completes but nothing is queued.
  assign w_push   = w_accept && (wb_regid != 4'd0);
  assign w_pop    = !rst && (r_count != '0) && !rf_hold;

  assign WriteEn       = w_pop;
  assign WriteWordline = w_pop ? (16'h0001 << r_regid[r_head]) : 16'h0000;
  assign WriteData     = w_pop ? r_data[r_head] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_ptr_one;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_regid[r_tail] <= wb_regid;
      r_data[r_tail]  <= wb_data;
    end
  end

  assign w_src[0] = SrcReg1;
  assign w_src[1] = SrcReg2;

  // Walk oldest to newest so the last match, i.e. the youngest write, wins.
  always_comb begin
    w_idx = '0;
    for (int p = 0; p < 2; p++) begin
      w_hit[p]   = 1'b0;
      w_fdata[p] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_idx = r_head + c_aw'(i);
        if (!rst && r_valid[w_idx] && (w_src[p] != 4'd0) &&
            (r_regid[w_idx] == w_src[p])) begin
          w_hit[p]   = 1'b1;
          w_fdata[p] = r_data[w_idx];
        end
      end
    end
  end

  assign fwd1_hit  = w_hit[0];
  assign fwd1_data = w_fdata[0];
  assign fwd2_hit  = w_hit[1];
  assign fwd2_data = w_fdata[1];

endmodule
`default_nettype wire
